// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient path: bank FSM states,
// coefficient word type and default bank geometry.
package fir_pkg;

  localparam int COEFF_W   = 16;
  localparam int NUM_COEFF = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } coeff_bank_state_t;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/coeff_write_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module coeff_write_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/coefficient_bank.sv
// Coefficient bank with multi-cycle writes and modwait handshake.
// Optional double buffering via `define COEFF_BANK_SHADOW_EN.
module coefficient_bank #(
  parameter int COEFF_W      = fir_pkg::COEFF_W,
  parameter int NUM_COEFF    = fir_pkg::NUM_COEFF,
  parameter int WRITE_CYCLES = 2,
  localparam int IDX_W       = $clog2(NUM_COEFF),
  localparam int BANK_W      = NUM_COEFF * COEFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_coeff,
  input  logic [IDX_W-1:0]  coefficient_num,
  input  logic              clear_coeff,
  input  logic [COEFF_W-1:0] coeff_data,
  output logic              modwait,
  output logic [BANK_W-1:0] coeffs,
  output logic [NUM_COEFF-1:0] loaded_mask,
  output logic              set_complete,
  output logic              load_overrun
);

  import fir_pkg::*;

  localparam int TW = $clog2(WRITE_CYCLES + 1);

  coeff_bank_state_t state_q, state_d;
  logic              modwait_q, modwait_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [COEFF_W-1:0] data_q, data_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [NUM_COEFF-1:0] mask_q, mask_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
`ifdef COEFF_BANK_SHADOW_EN
  logic [BANK_W-1:0] active_q, active_d;
`endif

  coeff_write_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(WRITE_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    modwait_d = modwait_q;
    idx_d     = idx_q;
    data_d    = data_q;
    bank_d    = bank_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
`ifdef COEFF_BANK_SHADOW_EN
    active_d  = active_q;
`endif
    if (clear_coeff) begin
      state_d   = IDLE;
      modwait_d = 1'b0;
      bank_d    = '0;
      mask_d    = '0;
`ifdef COEFF_BANK_SHADOW_EN
      active_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_coeff) begin
            idx_d     = coefficient_num;
            data_d    = coeff_data;
            state_d   = BUSY;
            modwait_d = 1'b1;
            tmr_load  = 1'b1;
          end
        end
        BUSY: begin
          ovr_d = load_coeff;
          if (tmr_zero) begin
            bank_d[idx_q*COEFF_W +: COEFF_W] = data_q;
            mask_d[idx_q] = 1'b1;
            done_d    = (idx_q == IDX_W'(NUM_COEFF - 1));
            state_d   = IDLE;
            modwait_d = 1'b0;
`ifdef COEFF_BANK_SHADOW_EN
            // publish the whole set only once its last entry lands
            if (done_d) begin
              active_d = bank_d;
            end
`endif
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      modwait_q <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      bank_q    <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef COEFF_BANK_SHADOW_EN
      active_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      modwait_q <= modwait_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      bank_q    <= bank_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
`ifdef COEFF_BANK_SHADOW_EN
      active_q  <= active_d;
`endif
    end
  end

  assign modwait      = modwait_q;
  assign loaded_mask  = mask_q;
  assign set_complete = done_q;
  assign load_overrun = ovr_q;
`ifdef COEFF_BANK_SHADOW_EN
  assign coeffs       = active_q;
`else
  assign coeffs       = bank_q;
`endif

endmodule

// File: tb/tb_coefficient_bank.sv
// Scoreboard bench for coefficient_bank: random loads, overruns,
// aborts and clears checked against a per-entry array model.
module tb_coefficient_bank;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_coeff;
  logic [1:0]    coefficient_num;
  logic          clear_coeff;
  logic [W-1:0]  coeff_data;
  logic          modwait;
  logic [N*W-1:0] coeffs;
  logic [N-1:0]  loaded_mask;
  logic          set_complete;
  logic          load_overrun;

  always #5 clk = ~clk;

  coefficient_bank #(
    .COEFF_W(W), .NUM_COEFF(N), .WRITE_CYCLES(WC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_coeff      (load_coeff),
    .coefficient_num (coefficient_num),
    .clear_coeff     (clear_coeff),
    .coeff_data      (coeff_data),
    .modwait         (modwait),
    .coeffs          (coeffs),
    .loaded_mask     (loaded_mask),
    .set_complete    (set_complete),
    .load_overrun    (load_overrun)
  );

  typedef struct {
    logic [N*W-1:0] cf;
    logic [N-1:0]   mask;
    logic           sc;
    int             run;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_shadow[N];
  logic [W-1:0] m_active[N];
  logic [N-1:0] m_mask;
  int n_checks = 0;
  int n_fail   = 0;
  int exp_sc   = 0;
  int exp_ovr  = 0;
  int seen_sc  = 0;
  int seen_ovr = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] model_coeffs();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = m_active[k];
    return r;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_mask = '0;
  endfunction

  function automatic void model_write(int idx, logic [W-1:0] d);
    m_shadow[idx] = d;
    m_mask[idx]   = 1'b1;
`ifdef COEFF_BANK_SHADOW_EN
    if (idx == N - 1)
      for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
`else
    m_active[idx] = d;
`endif
  endfunction

  task automatic wait_idle();
    int i = 0;
    while (modwait !== 1'b0 && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 20) check("idle_timeout", modwait, 0);
  endtask

  // mode 0: plain load, 1: extra load while busy, 2: clear in first busy cycle
  task automatic issue_load(int idx, logic [W-1:0] d, int mode);
    exp_t e;
    load_coeff      = 1'b1;
    coefficient_num = 2'(idx);
    coeff_data      = d;
    if (mode == 2) begin
      model_clear();
      e = '{cf: '0, mask: '0, sc: 1'b0, run: 1};
    end else begin
      model_write(idx, d);
      e = '{cf: model_coeffs(), mask: m_mask, sc: (idx == N - 1), run: WC};
      if (idx == N - 1) exp_sc++;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    load_coeff = 1'b0;
    if (mode == 1) begin
      load_coeff      = 1'b1;
      coefficient_num = 2'($urandom);
      coeff_data      = W'($urandom);
      exp_ovr++;
      @(posedge clk); #1;
      load_coeff = 1'b0;
    end else if (mode == 2) begin
      clear_coeff = 1'b1;
      @(posedge clk); #1;
      clear_coeff = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_clear(logic with_load);
    clear_coeff     = 1'b1;
    load_coeff      = with_load;
    coefficient_num = 2'($urandom);
    coeff_data      = W'($urandom);
    model_clear();
    @(posedge clk); #1;
    clear_coeff = 1'b0;
    load_coeff  = 1'b0;
  endtask

  // monitor: every falling modwait is one write outcome
  int  run_len = 0;
  logic prev_mw = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
      prev_mw = 1'b0;
    end else begin
      if (modwait === 1'b1) run_len++;
      if (prev_mw && modwait === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_end", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("coeffs", coeffs, e.cf);
          check("loaded_mask", loaded_mask, e.mask);
          check("set_complete", set_complete, e.sc);
          check("modwait_len", run_len, e.run);
        end
        run_len = 0;
      end
      if (set_complete === 1'b1) seen_sc++;
      if (load_overrun === 1'b1) seen_ovr++;
      prev_mw = (modwait === 1'b1);
    end
  end

  initial begin
    rst = 1'b1;
    load_coeff = 1'b1;
    clear_coeff = 1'b0;
    coefficient_num = 2'd3;
    coeff_data = 16'hDEAD;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_modwait", modwait, 0);
    check("rst_coeffs", coeffs, 0);
    check("rst_mask", loaded_mask, 0);
    check("rst_set_complete", set_complete, 0);
    check("rst_overrun", load_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    load_coeff = 1'b0;

    for (int i = 0; i < N; i++) issue_load(i, W'(i + 1), 0);
    @(negedge clk);
    check("full_set", coeffs, 64'h0004_0003_0002_0001);
    check("full_mask", loaded_mask, 4'hF);
    @(posedge clk); #1;

    do_clear(1'b0);
    issue_load(1, 16'h00AA, 1);
    @(negedge clk);
    check("ovr_idx1", coeffs[1*W +: W], 16'h00AA);
    check("ovr_idx2", coeffs[2*W +: W], 16'h0000);
    @(posedge clk); #1;

    issue_load(3, 16'h7FFF, 2);
    @(negedge clk);
    check("abort_coeffs", coeffs, 0);
    check("abort_mask", loaded_mask, 0);
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) issue_load(i, W'(i + 1), 0);
    issue_load(0, 16'h0010, 0);
    @(negedge clk);
`ifdef COEFF_BANK_SHADOW_EN
    check("shadow_hold", coeffs, 64'h0004_0003_0002_0001);
`else
    check("direct_update", coeffs, 64'h0004_0003_0002_0010);
`endif
    @(posedge clk); #1;
    issue_load(3, 16'h0004, 0);
    @(negedge clk);
    check("set_refresh", coeffs, 64'h0004_0003_0002_0010);
    @(posedge clk); #1;

    do_clear(1'b1);
    @(negedge clk);
    check("clr_load_coeffs", coeffs, 0);
    check("clr_load_mask", loaded_mask, 0);
    check("clr_load_modwait", modwait, 0);
    check("clr_load_overrun", load_overrun, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      int r;
      int mode;
      r = $urandom_range(0, 7);
      mode = (r < 2) ? 1 : (r == 2) ? 2 : 0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 15) == 0) do_clear($urandom_range(0, 1) == 1);
      issue_load($urandom_range(0, N - 1), W'($urandom), mode);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("final_coeffs", coeffs, model_coeffs());
    check("final_mask", loaded_mask, m_mask);
    check("pending_writes", exp_q.size(), 0);
    check("set_complete_count", seen_sc, exp_sc);
    check("overrun_count", seen_ovr, exp_ovr);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
